// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - calendar clock set-mode sequencer, 1 Hz prescaler, button debounce and blink
// Optional idle auto-exit from set mode is built when CLK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2,
  parameter int TIMEOUT_S   = 30
) (
  input  logic       built_in_clk,
  input  logic       glob_rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  output logic       run_tick,
  output logic [5:0] field_sel,
  output logic       field_inc,
  output logic       sec_clr,
  output logic [5:0] blank_mask,
  output logic       set_mode
);

  localparam int PRE_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DEB_MAX = DEB_CYC - 1;
  localparam int DEB_W   = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
  localparam int BLK_MAX = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int BLK_W   = (BLK_MAX > 0) ? $clog2(BLK_MAX + 1) : 1;

  typedef enum logic [2:0] {
    RUN, SET_YEAR, SET_MON, SET_DAY, SET_HOUR, SET_MIN, SET_SEC
  } state_t;

  state_t state, next_state;

  // Button path, bit 0 = mode, bit 1 = inc
  logic [1:0]       sync1, sync2, deb, deb_d, press;
  logic [DEB_W-1:0] deb_cnt [2];

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      deb   <= 2'b11;
      deb_d <= 2'b11;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_inc_n, btn_mode_n};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_MAX)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb_d & ~deb;

  logic timeout;

`ifdef CLK_SET_TIMEOUT_EN
  localparam int TO_MAX = TIMEOUT_S * CLK_HZ - 1;
  localparam int TO_W   = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      idle_cnt <= '0;
    end else if (next_state == RUN || press != 2'b00) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = (state != RUN) && (idle_cnt == TO_W'(TO_MAX));
`else
  // No idle exit in this build; the comparison is constant false.
  assign timeout = (TIMEOUT_S < 0);
`endif

  logic       inc_act, inc_d, clr_d;
  logic [5:0] sel_d;

  always_comb begin
    next_state = state;
    inc_act    = 1'b0;
    inc_d      = 1'b0;
    clr_d      = 1'b0;
    sel_d      = 6'b000000;
    if (press[0]) begin
      case (state)
        RUN:      next_state = SET_YEAR;
        SET_YEAR: next_state = SET_MON;
        SET_MON:  next_state = SET_DAY;
        SET_DAY:  next_state = SET_HOUR;
        SET_HOUR: next_state = SET_MIN;
        SET_MIN:  next_state = SET_SEC;
        default:  next_state = RUN;
      endcase
    end else if (timeout) begin
      next_state = RUN;
    end
    // A mode press in the same cycle swallows the inc press
    inc_act = press[1] && !press[0] && (state != RUN);
    inc_d   = inc_act && (state != SET_SEC);
    clr_d   = inc_act && (state == SET_SEC);
    case (next_state)
      SET_YEAR: sel_d = 6'b100000;
      SET_MON:  sel_d = 6'b010000;
      SET_DAY:  sel_d = 6'b001000;
      SET_HOUR: sel_d = 6'b000100;
      SET_MIN:  sel_d = 6'b000010;
      SET_SEC:  sel_d = 6'b000001;
      default:  sel_d = 6'b000000;
    endcase
  end

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      state     <= RUN;
      field_sel <= '0;
      field_inc <= 1'b0;
      sec_clr   <= 1'b0;
      set_mode  <= 1'b0;
    end else begin
      state     <= next_state;
      field_sel <= sel_d;
      field_inc <= inc_d;
      sec_clr   <= clr_d;
      set_mode  <= (next_state != RUN);
    end
  end

  // Cleared on both entry and exit edges so the first tick after set mode is a full period away
  logic [PRE_W-1:0] pre_cnt;

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      pre_cnt <= '0;
    end else if (state != RUN || next_state != RUN) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_W'(PRE_MAX)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign run_tick = (state == RUN) && (pre_cnt == PRE_W'(PRE_MAX));

  logic [BLK_W-1:0] blk_cnt;
  logic             phase;

  always_ff @(posedge built_in_clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (next_state == RUN || next_state != state || inc_act) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (blk_cnt == BLK_W'(BLK_MAX)) begin
      blk_cnt <= '0;
      phase   <= ~phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  assign blank_mask = phase ? field_sel : 6'b000000;

endmodule
